// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: data-memory handshake seen by the hazard unit.
// master drives request/ack; slave (hazard_ctrl) observes them.
interface hazard_ctrl_if;
  logic i_MemReq_M;
  logic i_MemReady;

  modport master (
    output i_MemReq_M,
    output i_MemReady
  );

  modport slave (
    input i_MemReq_M,
    input i_MemReady
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with memory-wait watchdog.
// Ports: clk, rst (sync, active-low); mem (req/ack); D/E/M/W regs;
//   o_Forward_*, o_Stall_F/D/E/M, o_Flush_D/E/W, o_MemTimeout.
// Macro HAZARD_FWD_EN: enables operand forwarding; when undefined,
//   RAW hazards on E/M destinations are resolved by stalling.
module hazard_ctrl #(
  parameter int Address_Width  = 5,
  parameter int Timeout_Cycles = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard_ctrl_if.slave             mem,
  input  logic [Address_Width-1:0] i_Rs1_D,
  input  logic [Address_Width-1:0] i_Rs2_D,
  input  logic [Address_Width-1:0] i_Rs1_E,
  input  logic [Address_Width-1:0] i_Rs2_E,
  input  logic [Address_Width-1:0] i_Rd_E,
  input  logic [Address_Width-1:0] i_Rd_M,
  input  logic [Address_Width-1:0] i_Rd_W,
  input  logic                     i_RegWrite_E,
  input  logic                     i_RegWrite_M,
  input  logic                     i_RegWrite_W,
  input  logic [1:0]               i_ResultSrc_E,
  input  logic                     i_PCSrc_E,
  output logic [1:0]               o_Forward_A_E,
  output logic [1:0]               o_Forward_B_E,
  output logic                     o_Stall_F,
  output logic                     o_Stall_D,
  output logic                     o_Stall_E,
  output logic                     o_Stall_M,
  output logic                     o_Flush_D,
  output logic                     o_Flush_E,
  output logic                     o_Flush_W,
  output logic                     o_MemTimeout
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] CntLast = 8'(Timeout_Cycles - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       timeout_q;

  logic mem_wait_req;
  logic mem_stall;
  logic ld_use;
  logic raw_stall;
  logic [1:0] fwd_a, fwd_b;

  assign mem_wait_req = mem.i_MemReq_M & ~mem.i_MemReady;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= NORMAL;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      timeout_q <= (state_nx == ERROR);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      NORMAL: begin
        if (mem_wait_req) begin
          state_nx = MEM_WAIT;
          cnt_nx   = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem.i_MemReady) begin
          state_nx = NORMAL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt == CntLast) state_nx = ERROR;
        end
      end
      ERROR:   state_nx = ERROR;
      default: begin
        state_nx = NORMAL;
        cnt_nx   = '0;
      end
    endcase
  end

  // ERROR keeps the pipeline frozen even once the request drops.
  assign mem_stall = mem_wait_req | (state == ERROR);

  assign ld_use = (i_ResultSrc_E == 2'b01) && (i_Rd_E != '0) &&
                  ((i_Rd_E == i_Rs1_D) || (i_Rd_E == i_Rs2_D));

`ifdef HAZARD_FWD_EN
  always_comb begin
    fwd_a = 2'b00;
    if (i_RegWrite_M && i_Rd_M != '0 && i_Rd_M == i_Rs1_E)
      fwd_a = 2'b10;
    else if (i_RegWrite_W && i_Rd_W != '0 && i_Rd_W == i_Rs1_E)
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (i_RegWrite_M && i_Rd_M != '0 && i_Rd_M == i_Rs2_E)
      fwd_b = 2'b10;
    else if (i_RegWrite_W && i_Rd_W != '0 && i_Rd_W == i_Rs2_E)
      fwd_b = 2'b01;
  end

  assign raw_stall = 1'b0;

  logic unused_nofwd;
  assign unused_nofwd = i_RegWrite_E;
`else
  logic raw_e, raw_m;

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  assign raw_e = i_RegWrite_E && (i_Rd_E != '0) &&
                 ((i_Rd_E == i_Rs1_D) || (i_Rd_E == i_Rs2_D));
  assign raw_m = i_RegWrite_M && (i_Rd_M != '0) &&
                 ((i_Rd_M == i_Rs1_D) || (i_Rd_M == i_Rs2_D));
  assign raw_stall = raw_e | raw_m;

  logic unused_fwd;
  assign unused_fwd = ^{i_Rs1_E, i_Rs2_E, i_Rd_W, i_RegWrite_W};
`endif

  // Priority: memory stall, then taken branch, then data hazard.
  always_comb begin
    o_Forward_A_E = 2'b00;
    o_Forward_B_E = 2'b00;
    o_Stall_F     = 1'b0;
    o_Stall_D     = 1'b0;
    o_Stall_E     = 1'b0;
    o_Stall_M     = 1'b0;
    o_Flush_D     = 1'b0;
    o_Flush_E     = 1'b0;
    o_Flush_W     = 1'b0;
    o_MemTimeout  = 1'b0;
    if (rst) begin
      o_Forward_A_E = fwd_a;
      o_Forward_B_E = fwd_b;
      o_MemTimeout  = timeout_q;
      if (mem_stall) begin
        o_Stall_F = 1'b1;
        o_Stall_D = 1'b1;
        o_Stall_E = 1'b1;
        o_Stall_M = 1'b1;
        o_Flush_W = 1'b1;
      end else if (i_PCSrc_E) begin
        o_Flush_D = 1'b1;
        o_Flush_E = 1'b1;
      end else if (ld_use | raw_stall) begin
        o_Stall_F = 1'b1;
        o_Stall_D = 1'b1;
        o_Flush_E = 1'b1;
      end
    end
  end

endmodule
